// File: rtl/lcd_bus_ctrl_pkg.sv
// Shared types and elaboration helpers for the HD44780-style LCD bus controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_t;

  localparam int TMR_W = 32;

  function automatic int us_to_cycles(int freq, int us);
    return (freq / 1_000_000) * us;
  endfunction

  function automatic bit cycles_ok(int t_setup, int t_pulse, int t_hold);
    return (t_setup >= 1) && (t_pulse >= 1) && (t_hold >= 1);
  endfunction

  function automatic bit data_w_ok(int data_w);
    return (data_w == 4) || (data_w == 8);
  endfunction

endpackage

// File: rtl/lcd_bus_ctrl_if.sv
// Request handshake and LCD pin bundle between the sequencer and the bus controller.
interface lcd_bus_ctrl_if #(
  parameter int DATA_W  = 4,
  parameter int DELAY_W = 21
) ();
  import lcd_pkg::*;

  // A request transfers on the edge where req_valid & req_ready; the requester
  // holds req_valid and the req_* fields stable until then, nothing is queued.
  logic               req_valid;
  logic               req_ready;
  logic               req_rs;
  logic [7:0]         req_data;
  logic               req_nibble;
  logic [DELAY_W-1:0] req_delay;
  logic [DATA_W-1:0]  LCD_D;
  logic               LCD_RS;
  logic               LCD_E;
  logic               busy;
  logic               done;
  lcd_state_t         dbg_state;

  modport master (
    output req_valid, req_rs, req_data, req_nibble, req_delay,
    input  req_ready, busy, done, LCD_D, LCD_RS, LCD_E, dbg_state
  );

  modport slave (
    input  req_valid, req_rs, req_data, req_nibble, req_delay,
    output req_ready, busy, done, LCD_D, LCD_RS, LCD_E, dbg_state
  );

endinterface

// File: rtl/lcd_bus_ctrl_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
module lcd_cycle_timer
  import lcd_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780-style bus controller: one byte or nibble per request with timed
// setup/pulse/hold phases, then a per-request settle delay before done.
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DATA_W      = 4,
  parameter int SETUP_US    = 1,
  parameter int E_PULSE_US  = 3,
  parameter int HOLD_US     = 1,
  parameter int DELAY_W     = 21
) (
  input logic           CLK,
  input logic           RST,
  lcd_bus_ctrl_if.slave bus
);

  localparam int T_SETUP   = us_to_cycles(CLK_FREQ_HZ, SETUP_US);
  localparam int T_E_PULSE = us_to_cycles(CLK_FREQ_HZ, E_PULSE_US);
  localparam int T_HOLD    = us_to_cycles(CLK_FREQ_HZ, HOLD_US);

  if (!data_w_ok(DATA_W)) begin : g_bad_width
    $error("lcd_bus_ctrl: DATA_W must be 4 or 8");
  end
  if (!cycles_ok(T_SETUP, T_E_PULSE, T_HOLD)) begin : g_bad_timing
    $error("lcd_bus_ctrl: every phase must last at least one clock cycle");
  end

  lcd_state_t         r_state, w_state_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_rs, w_rs_nxt, r_nib, w_nib_nxt, r_second, w_second_nxt;
  logic [DELAY_W-1:0] r_delay, w_delay_nxt, r_dly_cnt;
  logic               r_lcd_e, r_lcd_rs, r_done;
  logic [DATA_W-1:0]  r_lcd_d, w_d_sel;
  logic               w_accept, w_low_pend, w_dly_match, w_expired, w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_value;

  lcd_cycle_timer #(.W(TMR_W)) u_phase_timer (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (w_tmr_load),
    .i_value   (w_tmr_value),
    .o_expired (w_expired)
  );

  assign w_accept    = bus.req_valid && (r_state == IDLE);
  assign w_low_pend  = (DATA_W == 4) && !r_nib && !r_second;
  // Counter is zero on the E-fall cycle, so matching on cnt+1 lands done exactly req_delay later.
  assign w_dly_match = ({1'b0, r_dly_cnt} + (DELAY_W+1)'(1)) >= {1'b0, r_delay};

  if (DATA_W == 8) begin : g_bus8
    assign w_d_sel = w_byte_nxt;
  end else begin : g_bus4
    assign w_d_sel = w_second_nxt ? w_byte_nxt[3:0] : w_byte_nxt[7:4];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;
    w_byte_nxt   = r_byte;
    w_rs_nxt     = r_rs;
    w_nib_nxt    = r_nib;
    w_delay_nxt  = r_delay;
    w_second_nxt = r_second;
    unique case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt  = SETUP;
        w_tmr_load   = 1'b1;
        w_tmr_value  = TMR_W'(T_SETUP - 1);
        w_byte_nxt   = bus.req_data;
        w_rs_nxt     = bus.req_rs;
        w_nib_nxt    = bus.req_nibble;
        w_delay_nxt  = bus.req_delay;
        w_second_nxt = 1'b0;
      end
      SETUP: if (w_expired) begin
        w_state_nxt = PULSE;
        w_tmr_load  = 1'b1;
        w_tmr_value = TMR_W'(T_E_PULSE - 1);
      end
      PULSE: if (w_expired) begin
        w_state_nxt = HOLD;
        w_tmr_load  = 1'b1;
        w_tmr_value = TMR_W'(T_HOLD - 1);
      end
      HOLD: if (w_expired) begin
        if (w_low_pend) begin
          w_state_nxt  = SETUP;
          w_tmr_load   = 1'b1;
          w_tmr_value  = TMR_W'(T_SETUP - 1);
          w_second_nxt = 1'b1;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: if (w_dly_match) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pin registers are loaded from the next state so the strobe never glitches on decode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_byte    <= '0;
      r_rs      <= 1'b0;
      r_nib     <= 1'b0;
      r_second  <= 1'b0;
      r_delay   <= '0;
      r_dly_cnt <= '0;
      r_lcd_e   <= 1'b0;
      r_lcd_rs  <= 1'b0;
      r_lcd_d   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_byte    <= w_byte_nxt;
      r_rs      <= w_rs_nxt;
      r_nib     <= w_nib_nxt;
      r_second  <= w_second_nxt;
      r_delay   <= w_delay_nxt;
      r_dly_cnt <= (r_state == HOLD || r_state == WAIT) ? r_dly_cnt + DELAY_W'(1) : '0;
      r_lcd_e   <= (w_state_nxt == PULSE);
      r_lcd_rs  <= (w_state_nxt != IDLE) && w_rs_nxt;
      r_lcd_d   <= (w_state_nxt inside {SETUP, PULSE, HOLD}) ? w_d_sel : '0;
      r_done    <= (r_state == WAIT) && (w_state_nxt == IDLE);
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.LCD_E     = r_lcd_e;
  assign bus.LCD_RS    = r_lcd_rs;
  assign bus.LCD_D     = r_lcd_d;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: an 8-bit and a 4-bit instance at 50 MHz, table vectors,
// hand-written corner sequences and random requests against a timeline model.
module tb_lcd_bus_ctrl;
  import lcd_pkg::*;

  localparam int TS = 50;
  localparam int TE = 150;
  localparam int TH = 50;
  localparam int P  = TS + TE + TH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_bus_ctrl_if #(.DATA_W(8), .DELAY_W(21)) if8 ();
  lcd_bus_ctrl_if #(.DATA_W(4), .DELAY_W(21)) if4 ();

  lcd_bus_ctrl #(.CLK_FREQ_HZ(50_000_000), .DATA_W(8), .SETUP_US(1), .E_PULSE_US(3),
                 .HOLD_US(1), .DELAY_W(21)) u_dut8 (.CLK(clk), .RST(rst), .bus(if8));
  lcd_bus_ctrl #(.CLK_FREQ_HZ(50_000_000), .DATA_W(4), .SETUP_US(1), .E_PULSE_US(3),
                 .HOLD_US(1), .DELAY_W(21)) u_dut4 (.CLK(clk), .RST(rst), .bus(if4));

  typedef struct {
    bit         w8;
    bit         rs;
    logic [7:0] data;
    bit         nib;
    int         delay;
    int         npulse;
    int         rise0;
    int         fall0;
    int         rise1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         done_at;
  } vec_t;

  typedef struct {
    int         acc;
    int         done_abs;
    int         npulse;
    int         rise0;
    int         fall0;
    int         rise1;
    int         done_at;
    logic [7:0] d0;
    logic [7:0] d1;
  } meas_t;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Observed pins packed as {busy, ready, done, E, RS, D[7:0]}.
  function automatic logic [12:0] obs(bit w8);
    if (w8) return {if8.busy, if8.req_ready, if8.done, if8.LCD_E, if8.LCD_RS, if8.LCD_D};
    return {if4.busy, if4.req_ready, if4.done, if4.LCD_E, if4.LCD_RS, 4'h0, if4.LCD_D};
  endfunction

  function automatic int exp_done(bit w8, bit nib, int delay);
    int n = (w8 || nib) ? 1 : 2;
    int f = 1 + (n - 1) * P + TS + TE;
    return f + ((delay > TH + 1) ? delay : TH + 1);
  endfunction

  // Expected pins k cycles after the acceptance cycle, from the transfer timeline.
  function automatic logic [12:0] model(int k, bit w8, bit rs, logic [7:0] data, bit nib, int delay);
    int n = (w8 || nib) ? 1 : 2;
    int dn = exp_done(w8, nib, delay);
    int j = (k - 1) / P;
    int off = (k - 1) % P;
    logic e = 1'b0;
    logic [7:0] d = 8'h00;
    if (k >= dn) return {1'b0, 1'b1, (k == dn), 1'b0, 1'b0, 8'h00};
    if (j < n) begin
      e = (off >= TS) && (off < TS + TE);
      if (w8) d = data;
      else d = (j == 0) ? {4'h0, data[7:4]} : {4'h0, data[3:0]};
    end
    return {1'b1, 1'b0, 1'b0, e, rs, d};
  endfunction

  task automatic drive(bit w8, bit v, bit rs, logic [7:0] data, bit nib, int delay);
    if (w8) begin
      if8.req_valid = v; if8.req_rs = rs; if8.req_data = data;
      if8.req_nibble = nib; if8.req_delay = 21'(delay);
    end else begin
      if4.req_valid = v; if4.req_rs = rs; if4.req_data = data;
      if4.req_nibble = nib; if4.req_delay = 21'(delay);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle so a follow-on
  // call can be accepted in that same cycle.
  task automatic run_req(bit w8, bit rs, logic [7:0] data, bit nib, int delay, bit poke,
                         output meas_t m);
    int w = 0;
    int dn, bad_k;
    logic [12:0] o, e, bad_o, bad_e;
    bit bad = 0;
    bit prev_e = 0;
    m = '{acc: -1, done_abs: -1, npulse: 0, rise0: -1, fall0: -1, rise1: -1,
          done_at: -1, d0: 8'h00, d1: 8'h00};
    drive(w8, 1'b1, rs, data, nib, delay);
    o = obs(w8);
    while (o[11] !== 1'b1 && w < 50) begin
      @(negedge clk);
      o = obs(w8);
      w++;
    end
    check("ready before accept", int'(o[11]), 1);
    m.acc = cyc;
    @(negedge clk);
    drive(w8, 1'b0, rs, data, nib, delay);
    dn = exp_done(w8, nib, delay);
    for (int k = 1; k <= dn + 3; k++) begin
      if (poke && k == 5) drive(w8, 1'b1, ~rs, ~data, ~nib, delay + 7);
      if (poke && k == 8) drive(w8, 1'b0, rs, data, nib, delay);
      o = obs(w8);
      e = model(k, w8, rs, data, nib, delay);
      if (o !== e && !bad) begin
        bad = 1; bad_k = k; bad_o = o; bad_e = e;
      end
      if (o[9] && !prev_e) begin
        m.npulse++;
        if (m.npulse == 1) begin m.rise0 = k; m.d0 = o[7:0]; end
        else if (m.npulse == 2) begin m.rise1 = k; m.d1 = o[7:0]; end
      end
      if (!o[9] && prev_e && m.fall0 < 0) m.fall0 = k;
      prev_e = o[9];
      if (o[10]) begin
        m.done_at = k;
        m.done_abs = cyc;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL wave w8=%0d data=%02h delay=%0d k=%0d: got {busy,rdy,done,E,RS,D}=%04h, expected %04h",
               w8, data, delay, bad_k, bad_o, bad_e);
    end
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    meas_t m, m2;
    logic [12:0] o, o4;
    int cnt_e, cnt_d;

    vecs[0] = '{w8:1, rs:0, data:8'h38, nib:0, delay:2000, npulse:1, rise0:51, fall0:201,
                rise1:-1, d0:8'h38, d1:8'h00, done_at:2201};
    vecs[1] = '{w8:0, rs:1, data:8'hA5, nib:0, delay:100, npulse:2, rise0:51, fall0:201,
                rise1:301, d0:8'h0A, d1:8'h05, done_at:551};
    vecs[2] = '{w8:0, rs:0, data:8'h30, nib:1, delay:40, npulse:1, rise0:51, fall0:201,
                rise1:-1, d0:8'h03, d1:8'h00, done_at:252};
    vecs[3] = '{w8:1, rs:1, data:8'h01, nib:0, delay:0, npulse:1, rise0:51, fall0:201,
                rise1:-1, d0:8'h01, d1:8'h00, done_at:252};
    vecs[4] = '{w8:1, rs:0, data:8'hC3, nib:1, delay:60, npulse:1, rise0:51, fall0:201,
                rise1:-1, d0:8'hC3, d1:8'h00, done_at:261};
    vecs[5] = '{w8:0, rs:1, data:8'h28, nib:0, delay:51, npulse:2, rise0:51, fall0:201,
                rise1:301, d0:8'h02, d1:8'h08, done_at:502};

    // Clock/reset
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    o = obs(1'b1);
    check("reset outputs dut8", int'(o), 13'h800);
    o = obs(1'b0);
    check("reset outputs dut4", int'(o), 13'h800);
    rst = 1'b0;

    // Idle after reset: no strobe and no done on either instance.
    cnt_e = 0;
    cnt_d = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      o = obs(1'b1);
      o4 = obs(1'b0);
      cnt_e += int'(o[9]) + int'(o4[9]);
      cnt_d += int'(o[10]) + int'(o4[10]);
    end
    check("idle E pulses", cnt_e, 0);
    check("idle done pulses", cnt_d, 0);
    o = obs(1'b1);
    check("idle outputs dut8", int'(o), 13'h800);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].w8, vecs[i].rs, vecs[i].data, vecs[i].nib, vecs[i].delay, 1'b0, m);
      check($sformatf("v%0d npulse", i), m.npulse, vecs[i].npulse);
      check($sformatf("v%0d rise0", i), m.rise0, vecs[i].rise0);
      check($sformatf("v%0d fall0", i), m.fall0, vecs[i].fall0);
      check($sformatf("v%0d rise1", i), m.rise1, vecs[i].rise1);
      check($sformatf("v%0d d0", i), int'(m.d0), int'(vecs[i].d0));
      check($sformatf("v%0d d1", i), int'(m.d1), int'(vecs[i].d1));
      check($sformatf("v%0d done_at", i), m.done_at, vecs[i].done_at);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: second request accepted in the done cycle of the first.
    run_req(1'b1, 1'b1, 8'h81, 1'b0, 0, 1'b0, m);
    run_req(1'b1, 1'b0, 8'h6C, 1'b0, 10, 1'b0, m2);
    check("b2b accept in done cycle", m2.acc, m.done_abs);
    check("b2b second done_at", m2.done_at, 252);
    run_req(1'b0, 1'b1, 8'h9E, 1'b0, 0, 1'b0, m);
    run_req(1'b0, 1'b1, 8'h47, 1'b1, 0, 1'b0, m2);
    check("b2b4 accept in done cycle", m2.acc, m.done_abs);
    repeat (5) @(negedge clk);

    // Reset pulsed while E is high.
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 500);
    o = obs(1'b1);
    check("rst seq ready", int'(o[11]), 1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 500);
    repeat (99) @(negedge clk);
    o = obs(1'b1);
    check("rst seq E high before reset", int'(o[9]), 1);
    rst = 1'b1;
    @(negedge clk);
    o = obs(1'b1);
    check("rst seq outputs after reset", int'(o), 13'h800);
    rst = 1'b0;
    cnt_d = 0;
    cnt_e = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      o = obs(1'b1);
      cnt_d += int'(o[10]);
      cnt_e += int'(o[9]);
    end
    check("rst seq no done", cnt_d, 0);
    check("rst seq no E", cnt_e, 0);
    run_req(1'b1, 1'b0, 8'h5A, 1'b0, 100, 1'b0, m);
    check("rst seq recovery done_at", m.done_at, 301);

    // Random requests, some with a stray valid pulse while busy.
    for (int i = 0; i < 24; i++) begin
      bit w8, rs, nib, poke;
      logic [7:0] data;
      int delay;
      w8 = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      nib = 1'($urandom_range(0, 1));
      poke = ($urandom_range(0, 3) == 0);
      data = 8'($urandom_range(0, 255));
      delay = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 600);
      run_req(w8, rs, data, nib, delay, poke, m);
      check($sformatf("rand%0d done_at", i), m.done_at, exp_done(w8, nib, delay));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
